axil_reg_if_rd: RTL and testbench

AXI-Lite slave read-side adapter. It converts AR/R channel transactions into a simple single-cycle-ack register read strobe interface with a wait-extendable timeout. It pairs with the existing write-side register adapter so that a full AXI-Lite register slave can be assembled from the two. Registered outputs throughout; one outstanding read at a time.

---
 rtl/axil_reg_if_rd.sv | 118 +++++++++++
 tb/tb_axil_reg_if_rd.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_if_rd.sv
// AXI-Lite read-side register adapter: AR/R channels to a held read strobe with ack and a wait-extendable timeout.
// Optional build macro AXIL_REG_IF_RD_TIMEOUT_ERR_EN: timeout completions return SLVERR with zero data.
module axil_reg_if_rd #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  r_ar_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rd_en;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_ar_valid_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_rd_en_next;
  logic                  w_rvalid_next;
  logic [DATA_WIDTH-1:0] w_rdata_next;
  logic [1:0]            w_rresp_next;
  logic                  w_done;
  logic                  w_unused;

  // Protection bits and strobe width have no meaning on the read path.
  assign w_unused = ^{s_axil_arprot, (STRB_WIDTH > 0)};

  assign w_done = r_rd_en && (reg_rd_ack || (r_cnt == '0));

  always_comb begin
    w_ar_valid_next = r_ar_valid;
    w_addr_next     = r_addr;
    w_cnt_next      = r_cnt;
    w_rvalid_next   = r_rvalid && !s_axil_rready;
    w_rdata_next    = r_rdata;
    w_rresp_next    = r_rresp;

    if (w_done) begin
      w_ar_valid_next = 1'b0;
      w_rvalid_next   = 1'b1;
`ifdef AXIL_REG_IF_RD_TIMEOUT_ERR_EN
      if (reg_rd_ack) begin
        w_rdata_next = reg_rd_data;
        w_rresp_next = RESP_OKAY;
      end else begin
        w_rdata_next = '0;
        w_rresp_next = RESP_SLVERR;
      end
`else
      w_rdata_next = reg_rd_data;
      w_rresp_next = RESP_OKAY;
`endif
    end

    // The counter only runs while the strobe is out; a pending R beat holds it at its reload value.
    if (!r_ar_valid) begin
      w_addr_next     = s_axil_araddr;
      w_ar_valid_next = s_axil_arvalid;
      w_cnt_next      = CNT_INIT;
    end else if (r_rd_en && !reg_rd_wait && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - 1'b1;
    end

    w_rd_en_next = w_ar_valid_next && !w_rvalid_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_valid <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rd_en    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_ar_valid <= w_ar_valid_next;
      r_addr     <= w_addr_next;
      r_cnt      <= w_cnt_next;
      r_rd_en    <= w_rd_en_next;
      r_rvalid   <= w_rvalid_next;
      r_rdata    <= w_rdata_next;
      r_rresp    <= w_rresp_next;
    end
  end

  assign s_axil_arready = !r_ar_valid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rvalid  = r_rvalid;
  assign reg_rd_addr    = r_addr;
  assign reg_rd_en      = r_rd_en;

endmodule

// File: tb/tb_axil_reg_if_rd.sv
// Scoreboard bench for axil_reg_if_rd: planned register responses, expected R beats queued at AR acceptance.
module tb_axil_reg_if_rd;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data = '0;
  logic        reg_rd_wait = 1'b0;
  logic        reg_rd_ack = 1'b0;

  axil_reg_if_rd #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          w;     // leading strobe cycles with wait held high
    int          a;     // strobe cycle index carrying ack, -1 for none
    logic [31:0] data;
    logic [31:0] junk;  // data bus value on cycles without ack
    int          dur;   // expected strobe length in cycles
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rr_mode = 2;   // 0: ready, 1: random, 2: not ready
  bit    active = 1'b0;
  int    k = 0;
  plan_t cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=expired required=event", name);
  endtask

  task automatic issue_read(input logic [31:0] addr, input int w, input int a, input logic [31:0] data);
    plan_t p;
    exp_t  e;
    int    last;
    int    n;
    p.addr = addr; p.w = w; p.a = a; p.data = data; p.junk = $urandom;
    last = w + TIMEOUT - 1;
    if (a >= 0 && a <= last) begin
      p.dur = a + 1;
      e.rdata = data;
      e.rresp = 2'b00;
    end else begin
      p.dur = w + TIMEOUT;
`ifdef AXIL_REG_IF_RD_TIMEOUT_ERR_EN
      e.rdata = 32'h0;
      e.rresp = 2'b10;
`else
      e.rdata = p.junk;
      e.rresp = 2'b00;
`endif
    end
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = addr;
    n = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      n++;
      if (n > 200) begin
        fail_now("ar_accept_timeout");
        arvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    plan_q.push_back(p);
    exp_q.push_back(e);
    #1;
    arvalid = 1'b0;
    araddr  = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (plan_q.size() != 0 || exp_q.size() != 0 || active || rvalid || reg_rd_en) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        fail_now("idle_timeout");
        return;
      end
    end
  endtask

  // R ready driver
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = 1'($urandom_range(0, 1));
      default: rready = 1'b0;
    endcase
  end

  // Register-side responder following the per-read plan
  initial forever begin
    @(posedge clk); #2;
    if (rst) begin
      active = 1'b0;
      reg_rd_ack = 1'b0;
      reg_rd_wait = 1'b0;
      continue;
    end
    if (reg_rd_en) begin
      if (!active) begin
        if (plan_q.size() == 0) begin
          fail_now("unexpected_strobe");
          cur.addr = reg_rd_addr; cur.w = 0; cur.a = 0; cur.data = '0; cur.junk = '0; cur.dur = 1;
        end else begin
          cur = plan_q.pop_front();
        end
        active = 1'b1;
        k = 0;
        chk("reg_rd_addr", {32'h0, reg_rd_addr}, {32'h0, cur.addr});
      end else begin
        k++;
      end
      reg_rd_wait = (k < cur.w);
      reg_rd_ack  = (k == cur.a);
      reg_rd_data = reg_rd_ack ? cur.data : cur.junk;
    end else begin
      if (active) begin
        chk("strobe_len", 64'(k + 1), 64'(cur.dur));
        active = 1'b0;
      end
      reg_rd_ack  = 1'b0;
      reg_rd_wait = 1'b0;
      reg_rd_data = $urandom;
    end
  end

  // R channel monitor
  initial begin
    bit          pend = 1'b0;
    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        continue;
      end
      if (rvalid) begin
        chk("no_strobe_while_r_pending", {63'h0, reg_rd_en}, 64'h0);
        if (pend) begin
          chk("rdata_stable", {32'h0, rdata}, {32'h0, hold_d});
          chk("rresp_stable", {62'h0, rresp}, {62'h0, hold_r});
        end
        if (rready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_r_beat");
          end else begin
            e = exp_q.pop_front();
            chk("rdata", {32'h0, rdata}, {32'h0, e.rdata});
            chk("rresp", {62'h0, rresp}, {62'h0, e.rresp});
          end
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          hold_d = rdata;
          hold_r = rresp;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int w;
    int a;
    #3;
    chk("rst_arready", {63'h0, arready}, 64'h1);
    chk("rst_rvalid", {63'h0, rvalid}, 64'h0);
    chk("rst_rresp", {62'h0, rresp}, 64'h0);
    chk("rst_rdata", {32'h0, rdata}, 64'h0);
    chk("rst_reg_rd_en", {63'h0, reg_rd_en}, 64'h0);
    chk("rst_reg_rd_addr", {32'h0, reg_rd_addr}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rr_mode = 0;

    issue_read(32'h10, 0, 1, 32'hDEADBEEF);
    wait_idle(100);
    issue_read(32'h14, 0, -1, 32'h11112222);
    wait_idle(100);
    issue_read(32'h18, 10, -1, 32'h33334444);
    wait_idle(100);
    issue_read(32'h1C, 0, TIMEOUT - 1, 32'h5A5A5A5A);
    wait_idle(100);

    // R backpressure with a second AR accepted behind the pending beat
    rr_mode = 2;
    issue_read(32'h0C, 0, 1, 32'hCAFEF00D);
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rvalid_rose", {63'h0, rvalid}, 64'h1);
    issue_read(32'h20, 0, 0, 32'h0BADC0DE);
    @(negedge clk);
    chk("bp_r_still_pending", {63'h0, rvalid}, 64'h1);
    chk("bp_strobe_held_low", {63'h0, reg_rd_en}, 64'h0);
    repeat (5) @(negedge clk);
    rr_mode = 0;
    n = 0;
    while (rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_strobe_after_r", {63'h0, reg_rd_en}, 64'h1);
    chk("bp_second_addr", {32'h0, reg_rd_addr}, 64'h20);
    wait_idle(100);

    // Reset in the middle of a long strobe
    issue_read(32'h30, 20, -1, 32'h77778888);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_reg_rd_en", {63'h0, reg_rd_en}, 64'h0);
    chk("mid_rst_rvalid", {63'h0, rvalid}, 64'h0);
    chk("mid_rst_arready", {63'h0, arready}, 64'h1);
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issue_read(32'h44, 0, 0, 32'h600DF00D);
    wait_idle(100);

    // Randomized traffic with random R backpressure
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      a = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, w + TIMEOUT));
      issue_read({22'h0, 8'($urandom_range(0, 255)), 2'b00}, w, a, $urandom);
    end
    rr_mode = 0;
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=expired required=finish");
    $fatal(1);
  end
endmodule
